win_stats_gen: RTL and testbench
================================

WIN_STATS_GEN -- requirements
Module: win_stats_gen

Interface
REQ-001 Parameter DW, default 3, bit width of one pixel sample.
REQ-002 Parameter WIN, default 16, window length in samples (power of two, >=2).
REQ-003 Parameter XSPAN, default 79, accepted sample pairs per row (XSPAN >= WIN).
REQ-004 Parameter ROWS, default 16, rows per frame.
REQ-005 Derived widths: SW = DW+log2(WIN) for linear sums; QW = 2*DW+log2(WIN) for square sums; XW = ceil(log2(XSPAN)); YW = ceil(log2(ROWS)).
REQ-006 One clock; reset is synchronous and active-high.
REQ-007 clk  in  1  sole clock; all state updates on rising edge.
REQ-008 rst  in  1  synchronous active-high reset.
REQ-009 start  in  1  frame start request; sampled only in IDLE.
REQ-010 pix_valid  in  1  f_pix/g_pix pair offered.
REQ-011 f_pix  in  DW  template-image sample.
REQ-012 g_pix  in  DW  search-image sample.
REQ-013 pix_ready  out  1  block accepts a pair this cycle.
REQ-014 f_win  out  WIN*DW  template window; slot 0 in bits [DW-1:0], oldest sample.
REQ-015 f_sum / f2_sum  out  SW / QW  sum and sum of squares of template samples in current row.
REQ-016 g_sum / g2_sum  out  SW / QW  sliding sum and sum of squares of last WIN g samples.
REQ-017 xg  out  XW  index of last accepted pair in row; xf  out  log2(WIN)  xg mod WIN; y  out  YW  row index.
REQ-018 slot  out  WIN  one-hot, bit (xg mod WIN) set after each accepted pair.
REQ-019 out_valid  out  1  one-cycle pulse: window statistics valid.
REQ-020 row_done / frame_done  out  1  one-cycle pulses at end of row / frame.
REQ-021 busy  out  1  high in every state except IDLE.

Function
REQ-022 FSM states IDLE, LINE, RUN, NEXT; IDLE->LINE on start; LINE->RUN after one cycle; RUN->NEXT on acceptance of pair with xg==XSPAN-1; NEXT->LINE if y<ROWS-1 else ->IDLE.
REQ-023 pix_ready SHALL be high exactly in RUN; a pair is accepted when pix_valid && pix_ready.
REQ-024 LINE SHALL clear f_win, f_sum, f2_sum, g_sum, g2_sum, the internal g history, xg, xf, slot; y retained.
REQ-025 On acceptance with pair count k (0-based) < WIN: f_win shifts down one slot, f_pix enters slot WIN-1, f_sum += f_pix, f2_sum += f_pix^2; for k >= WIN f_win, f_sum, f2_sum hold.
REQ-026 On every acceptance: g_sum += g_pix - g_old, g2_sum += g_pix^2 - g_old^2, g_old = sample accepted WIN pairs earlier in this row, 0 if none.
REQ-027 All outputs registered; outputs reflect accepted pair k on the cycle after acceptance (latency 1).
REQ-028 out_valid SHALL pulse on the cycle after acceptance of every pair with k >= WIN-1; exactly XSPAN-WIN+1 pulses per row.
REQ-029 Sums SHALL never overflow: widths per REQ-005 are exact for maximal samples.
REQ-030 row_done pulses in NEXT; y increments in NEXT, wraps to 0 when y==ROWS-1, and frame_done pulses in the same cycle.
REQ-031 start outside IDLE SHALL be ignored; start asserted in the same cycle frame_done pulses SHALL be ignored (IDLE reached next cycle).
REQ-032 pix_valid outside RUN SHALL have no effect; stalls (pix_valid low in RUN) hold all state.

Reset
REQ-033 rst high SHALL, on the next rising edge, force IDLE and zero every output and internal register, regardless of state, overriding start and pix_valid.
REQ-034 Reset mid-row SHALL discard the partial row; the next frame begins at y=0 with no stale g history.

Verification
REQ-035 WIN=4,XSPAN=6,ROWS=2; start, f=1,2,3,4,5,6, g=1..6 -> f_sum=10, f2_sum=30 after k=3 and held; g_sum after k=3,4,5 = 10,14,18; out_valid exactly 3 pulses.
REQ-036 Same config, two rows streamed -> row_done twice, frame_done once coincident with second row_done, y returns to 0, busy low afterwards.
REQ-037 DW=3,WIN=16, all samples 7 for XSPAN=79 -> f_sum=112, f2_sum=784, g_sum=112 from k=15 on, no overflow.
REQ-038 Random pix_valid gaps in RUN -> results identical to gapless run; pix_ready low in LINE/NEXT/IDLE.
REQ-039 rst asserted at k=2 of row 1 -> next cycle all outputs 0, IDLE; restart gives results identical to REQ-035.
REQ-040 start pulsed while busy and during frame_done -> no extra frame, y/xg sequence unchanged.

Source files
------------

// File: rtl/win_stats_if.sv
// -----------------------------------------------------------------------------
// win_stats_if
// Pixel-pair stream between a pixel source and win_stats_gen.
//   pix_valid : source offers an f_pix/g_pix pair this cycle
//   f_pix     : template-image sample (DW bits)
//   g_pix     : search-image sample   (DW bits)
//   pix_ready : sink accepts the offered pair this cycle
// A pair transfers on a cycle where pix_valid && pix_ready.
// -----------------------------------------------------------------------------
interface win_stats_if #(
    parameter int DW = 3
);
    logic          pix_valid;
    logic [DW-1:0] f_pix;
    logic [DW-1:0] g_pix;
    logic          pix_ready;

    modport master (output pix_valid, output f_pix, output g_pix, input  pix_ready);
    modport slave  (input  pix_valid, input  f_pix, input  g_pix, output pix_ready);
endinterface

// File: rtl/win_stats_gen.sv
// -----------------------------------------------------------------------------
// win_stats_gen
// Walks a frame of ROWS rows, XSPAN pixel pairs per row, and produces
// running window statistics for template matching:
//   - template window (first WIN f samples of the row) with sum / sum of squares
//   - sliding sum / sum of squares over the last WIN g samples
// Ports:
//   i_clk, i_rst      : clock, synchronous active-high reset
//   i_start           : frame start request (only honoured in IDLE)
//   pix_if (slave)    : pixel-pair stream, pix_ready high only in RUN
//   o_f_win           : template window, slot 0 (bits [DW-1:0]) is the oldest
//   o_f_sum/o_f2_sum  : sum / sum of squares of template samples in this row
//   o_g_sum/o_g2_sum  : sliding sum / sum of squares of the last WIN g samples
//   o_xg, o_xf, o_y   : last accepted pair index, index mod WIN, row index
//   o_slot            : one-hot of o_xf
//   o_out_valid       : window statistics valid (pulse)
//   o_row_done        : end of row (pulse), o_frame_done : end of frame (pulse)
//   o_busy            : block is not idle
// All outputs are registered and reflect an accepted pair one cycle later.
// -----------------------------------------------------------------------------
module win_stats_gen #(
    parameter  int DW    = 3,
    parameter  int WIN   = 16,
    parameter  int XSPAN = 79,
    parameter  int ROWS  = 16,
    localparam int LW    = $clog2(WIN),
    localparam int SW    = DW + LW,
    localparam int QW    = 2 * DW + LW,
    localparam int XW    = $clog2(XSPAN),
    localparam int YW    = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    win_stats_if.slave        pix_if,
    output logic [WIN*DW-1:0] o_f_win,
    output logic [SW-1:0]     o_f_sum,
    output logic [QW-1:0]     o_f2_sum,
    output logic [SW-1:0]     o_g_sum,
    output logic [QW-1:0]     o_g2_sum,
    output logic [XW-1:0]     o_xg,
    output logic [LW-1:0]     o_xf,
    output logic [YW-1:0]     o_y,
    output logic [WIN-1:0]    o_slot,
    output logic              o_out_valid,
    output logic              o_row_done,
    output logic              o_frame_done,
    output logic              o_busy
);

    typedef enum logic [1:0] {S_IDLE, S_LINE, S_RUN, S_NEXT} state_t;

    // r_k counts accepted pairs in the row; one extra bit so WIN==XSPAN fits.
    localparam logic [XW:0]   K_LAST = (XW+1)'(XSPAN - 1);
    localparam logic [XW:0]   K_WIN  = (XW+1)'(WIN);
    localparam logic [XW:0]   K_WIN1 = (XW+1)'(WIN - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(ROWS - 1);

    state_t              r_state;
    logic                r_pix_ready;
    logic                r_busy;
    logic                r_row_done;
    logic                r_frame_done;
    logic [YW-1:0]       r_y;
    logic [XW:0]         r_k;
    logic [XW-1:0]       r_xg;
    logic [LW-1:0]       r_xf;
    logic [WIN-1:0]      r_slot;
    logic                r_out_valid;
    logic [WIN*DW-1:0]   r_f_win;
    logic [WIN*DW-1:0]   r_g_hist;
    logic [SW-1:0]       r_f_sum;
    logic [QW-1:0]       r_f2_sum;
    logic [SW-1:0]       r_g_sum;
    logic [QW-1:0]       r_g2_sum;

    logic                w_accept;
    logic                w_last;
    logic [DW-1:0]       w_g_old;

    // Zero-extend a sample to the linear-sum width.
    function automatic logic [SW-1:0] lin_ext(input logic [DW-1:0] v);
        return {{LW{1'b0}}, v};
    endfunction

    // Square a sample and zero-extend it to the square-sum width.
    function automatic logic [QW-1:0] sq_ext(input logic [DW-1:0] v);
        logic [2*DW-1:0] p;
        p = {{DW{1'b0}}, v} * {{DW{1'b0}}, v};
        return {{LW{1'b0}}, p};
    endfunction

    // r_pix_ready is high exactly in RUN, so acceptance implies RUN.
    assign w_accept = pix_if.pix_valid & r_pix_ready;
    assign w_last   = w_accept & (r_k == K_LAST);
    // Bottom of the history is the sample accepted WIN pairs ago (0 after LINE).
    assign w_g_old  = r_g_hist[DW-1:0];

    // Frame/row sequencing FSM with its registered control outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_pix_ready  <= 1'b0;
            r_busy       <= 1'b0;
            r_row_done   <= 1'b0;
            r_frame_done <= 1'b0;
            r_y          <= '0;
        end else begin
            r_row_done   <= 1'b0;
            r_frame_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_state <= S_LINE;
                        r_busy  <= 1'b1;
                    end
                end
                S_LINE: begin
                    r_state     <= S_RUN;
                    r_pix_ready <= 1'b1;
                end
                S_RUN: begin
                    if (w_last) begin
                        r_state      <= S_NEXT;
                        r_pix_ready  <= 1'b0;
                        r_row_done   <= 1'b1;
                        r_frame_done <= (r_y == Y_LAST);
                    end
                end
                S_NEXT: begin
                    if (r_y == Y_LAST) begin
                        r_y     <= '0;
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_y     <= r_y + YW'(1);
                        r_state <= S_LINE;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_pix_ready <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    // Window datapath: cleared in LINE, updated on each accepted pair.
    always_ff @(posedge i_clk) begin
        if (i_rst || (r_state == S_LINE)) begin
            r_k         <= '0;
            r_xg        <= '0;
            r_xf        <= '0;
            r_slot      <= '0;
            r_out_valid <= 1'b0;
            r_f_win     <= '0;
            r_g_hist    <= '0;
            r_f_sum     <= '0;
            r_f2_sum    <= '0;
            r_g_sum     <= '0;
            r_g2_sum    <= '0;
        end else begin
            r_out_valid <= 1'b0;
            if (w_accept) begin
                r_k         <= r_k + (XW+1)'(1);
                r_xg        <= r_k[XW-1:0];
                r_xf        <= r_k[LW-1:0];
                r_slot      <= WIN'(1) << r_k[LW-1:0];
                r_out_valid <= (r_k >= K_WIN1);
                r_g_hist    <= {pix_if.g_pix, r_g_hist[WIN*DW-1:DW]};
                // Modular add/subtract: the true result is never negative.
                r_g_sum     <= r_g_sum + lin_ext(pix_if.g_pix) - lin_ext(w_g_old);
                r_g2_sum    <= r_g2_sum + sq_ext(pix_if.g_pix) - sq_ext(w_g_old);
                // Template window freezes once it has WIN samples.
                if (r_k < K_WIN) begin
                    r_f_win  <= {pix_if.f_pix, r_f_win[WIN*DW-1:DW]};
                    r_f_sum  <= r_f_sum + lin_ext(pix_if.f_pix);
                    r_f2_sum <= r_f2_sum + sq_ext(pix_if.f_pix);
                end
            end
        end
    end

    assign pix_if.pix_ready = r_pix_ready;
    assign o_f_win          = r_f_win;
    assign o_f_sum          = r_f_sum;
    assign o_f2_sum         = r_f2_sum;
    assign o_g_sum          = r_g_sum;
    assign o_g2_sum         = r_g2_sum;
    assign o_xg             = r_xg;
    assign o_xf             = r_xf;
    assign o_y              = r_y;
    assign o_slot           = r_slot;
    assign o_out_valid      = r_out_valid;
    assign o_row_done       = r_row_done;
    assign o_frame_done     = r_frame_done;
    assign o_busy           = r_busy;

endmodule

// File: tb/tb_win_stats_gen.sv
// -----------------------------------------------------------------------------
// tb_win_stats_gen
// Directed bench for win_stats_gen. DUT a: DW=3, WIN=4, XSPAN=6, ROWS=2.
// DUT b: default parameters (DW=3, WIN=16, XSPAN=79, ROWS=16), all-max samples.
// Inputs are driven and outputs sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_win_stats_gen;

    logic clk;
    logic rst;
    logic start_a;
    logic start_b;

    win_stats_if #(.DW(3)) if_a ();
    win_stats_if #(.DW(3)) if_b ();

    logic [11:0] a_f_win;
    logic [4:0]  a_f_sum, a_g_sum;
    logic [7:0]  a_f2_sum, a_g2_sum;
    logic [2:0]  a_xg;
    logic [1:0]  a_xf;
    logic [0:0]  a_y;
    logic [3:0]  a_slot;
    logic        a_ov, a_rd, a_fd, a_busy;

    logic [47:0] b_f_win;
    logic [6:0]  b_f_sum, b_g_sum;
    logic [9:0]  b_f2_sum, b_g2_sum;
    logic [6:0]  b_xg;
    logic [3:0]  b_xf;
    logic [3:0]  b_y;
    logic [15:0] b_slot;
    logic        b_ov, b_rd, b_fd, b_busy;

    int n_asserts = 0;
    int n_fail    = 0;
    int cnt_ov    = 0;
    int cnt_rd    = 0;
    int cnt_fd    = 0;
    int base_ov, base_rd, base_fd;

    win_stats_gen #(.DW(3), .WIN(4), .XSPAN(6), .ROWS(2)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_start(start_a), .pix_if(if_a),
        .o_f_win(a_f_win), .o_f_sum(a_f_sum), .o_f2_sum(a_f2_sum),
        .o_g_sum(a_g_sum), .o_g2_sum(a_g2_sum), .o_xg(a_xg), .o_xf(a_xf),
        .o_y(a_y), .o_slot(a_slot), .o_out_valid(a_ov), .o_row_done(a_rd),
        .o_frame_done(a_fd), .o_busy(a_busy)
    );

    win_stats_gen dut_b (
        .i_clk(clk), .i_rst(rst), .i_start(start_b), .pix_if(if_b),
        .o_f_win(b_f_win), .o_f_sum(b_f_sum), .o_f2_sum(b_f2_sum),
        .o_g_sum(b_g_sum), .o_g2_sum(b_g2_sum), .o_xg(b_xg), .o_xf(b_xf),
        .o_y(b_y), .o_slot(b_slot), .o_out_valid(b_ov), .o_row_done(b_rd),
        .o_frame_done(b_fd), .o_busy(b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters for DUT a (values seen just before each rising edge).
    always @(posedge clk) begin
        if (a_ov) cnt_ov <= cnt_ov + 1;
        if (a_rd) cnt_rd <= cnt_rd + 1;
        if (a_fd) cnt_fd <= cnt_fd + 1;
    end

    // Hard stop in case the sequence stalls.
    initial begin
        #100000;
        $display("FAIL timeout: bench did not reach its end");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic pair_a(input logic [2:0] f, input logic [2:0] g, input int gap);
        if_a.pix_valid = 1'b0;
        for (int i = 0; i < gap; i++) step();
        if_a.pix_valid = 1'b1;
        if_a.f_pix     = f;
        if_a.g_pix     = g;
        step();
        if_a.pix_valid = 1'b0;
        if_a.f_pix     = 3'd0;
        if_a.g_pix     = 3'd0;
    endtask

    task automatic pair_b(input logic [2:0] f, input logic [2:0] g);
        if_b.pix_valid = 1'b1;
        if_b.f_pix     = f;
        if_b.g_pix     = g;
        step();
        if_b.pix_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
        if_a.pix_valid = 1'b0; if_a.f_pix = 3'd0; if_a.g_pix = 3'd0;
        if_b.pix_valid = 1'b0; if_b.f_pix = 3'd0; if_b.g_pix = 3'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);

        // Reset state
        chk("rst_busy",  a_busy, 1'b0);
        chk("rst_ready", if_a.pix_ready, 1'b0);
        chk("rst_fsum",  a_f_sum, 5'd0);
        chk("rst_y",     a_y, 1'b0);
        chk("rst_ov",    a_ov, 1'b0);
        rst = 1'b0;
        // pix_valid outside RUN has no effect
        if_a.pix_valid = 1'b1; if_a.f_pix = 3'd5; if_a.g_pix = 3'd5;
        step();
        if_a.pix_valid = 1'b0;
        chk("idle_busy", a_busy, 1'b0);
        chk("idle_gsum", a_g_sum, 5'd0);
        base_ov = cnt_ov; base_rd = cnt_rd; base_fd = cnt_fd;

        // Frame 1, row 0, gapless
        start_a = 1'b1; step(); start_a = 1'b0;
        chk("line_busy",  a_busy, 1'b1);
        chk("line_ready", if_a.pix_ready, 1'b0);
        step();
        chk("run_ready", if_a.pix_ready, 1'b1);
        pair_a(3'd1, 3'd1, 0);
        chk("k0_fsum", a_f_sum, 5'd1);
        chk("k0_f2",   a_f2_sum, 8'd1);
        chk("k0_gsum", a_g_sum, 5'd1);
        chk("k0_ov",   a_ov, 1'b0);
        chk("k0_slot", a_slot, 4'b0001);
        pair_a(3'd2, 3'd2, 0);
        pair_a(3'd3, 3'd3, 0);
        chk("k2_ov", a_ov, 1'b0);
        pair_a(3'd4, 3'd4, 0);
        chk("k3_fsum", a_f_sum, 5'd10);
        chk("k3_f2",   a_f2_sum, 8'd30);
        chk("k3_gsum", a_g_sum, 5'd10);
        chk("k3_g2",   a_g2_sum, 8'd30);
        chk("k3_ov",   a_ov, 1'b1);
        chk("k3_fwin", a_f_win, 12'h8D1);
        chk("k3_slot", a_slot, 4'b1000);
        chk("k3_xf",   a_xf, 2'd3);
        // Stall with start pulsed while busy
        start_a = 1'b1; step(); start_a = 1'b0;
        chk("stall_ov",   a_ov, 1'b0);
        chk("stall_gsum", a_g_sum, 5'd10);
        chk("stall_xg",   a_xg, 3'd3);
        pair_a(3'd5, 3'd5, 0);
        chk("k4_gsum", a_g_sum, 5'd14);
        chk("k4_g2",   a_g2_sum, 8'd54);
        chk("k4_fsum", a_f_sum, 5'd10);
        chk("k4_xg",   a_xg, 3'd4);
        chk("k4_slot", a_slot, 4'b0001);
        pair_a(3'd6, 3'd6, 0);
        chk("k5_gsum",  a_g_sum, 5'd18);
        chk("k5_g2",    a_g2_sum, 8'd86);
        chk("k5_ov",    a_ov, 1'b1);
        chk("k5_rd",    a_rd, 1'b1);
        chk("k5_fd",    a_fd, 1'b0);
        chk("k5_ready", if_a.pix_ready, 1'b0);
        chk("k5_fwin",  a_f_win, 12'h8D1);
        step();
        chk("row1_y",    a_y, 1'b1);
        chk("row1_rd",   a_rd, 1'b0);
        chk("row1_busy", a_busy, 1'b1);
        step();
        chk("row1_clr_gsum", a_g_sum, 5'd0);
        chk("row1_clr_fwin", a_f_win, 12'h000);
        chk("row1_clr_xg",   a_xg, 3'd0);

        // Row 1 with gaps: same results as gapless
        pair_a(3'd1, 3'd1, 2);
        pair_a(3'd2, 3'd2, 1);
        pair_a(3'd3, 3'd3, 0);
        pair_a(3'd4, 3'd4, 3);
        chk("gap_k3_fsum", a_f_sum, 5'd10);
        chk("gap_k3_gsum", a_g_sum, 5'd10);
        chk("gap_k3_g2",   a_g2_sum, 8'd30);
        chk("gap_k3_fwin", a_f_win, 12'h8D1);
        pair_a(3'd5, 3'd5, 1);
        pair_a(3'd6, 3'd6, 2);
        chk("gap_k5_gsum", a_g_sum, 5'd18);
        chk("gap_k5_g2",   a_g2_sum, 8'd86);
        chk("gap_k5_xg",   a_xg, 3'd5);
        chk("frame_rd",    a_rd, 1'b1);
        chk("frame_fd",    a_fd, 1'b1);
        start_a = 1'b1; step(); start_a = 1'b0;
        chk("end_y",    a_y, 1'b0);
        chk("end_busy", a_busy, 1'b0);
        chk("end_fd",   a_fd, 1'b0);
        step();
        chk("no_extra_frame", a_busy, 1'b0);
        chk("cnt_ov", cnt_ov - base_ov, 6);
        chk("cnt_rd", cnt_rd - base_rd, 2);
        chk("cnt_fd", cnt_fd - base_fd, 1);

        // Reset at k=2 of row 1
        start_a = 1'b1; step(); start_a = 1'b0;
        step();
        for (int i = 1; i <= 6; i++) pair_a(3'(i), 3'(i), 0);
        step(); step();
        pair_a(3'd1, 3'd1, 0);
        pair_a(3'd2, 3'd2, 0);
        pair_a(3'd3, 3'd3, 0);
        chk("pre_rst_y", a_y, 1'b1);
        rst = 1'b1; step(); rst = 1'b0;
        chk("mrst_busy",  a_busy, 1'b0);
        chk("mrst_ready", if_a.pix_ready, 1'b0);
        chk("mrst_y",     a_y, 1'b0);
        chk("mrst_gsum",  a_g_sum, 5'd0);
        chk("mrst_g2",    a_g2_sum, 8'd0);
        chk("mrst_fsum",  a_f_sum, 5'd0);
        chk("mrst_fwin",  a_f_win, 12'h000);
        chk("mrst_slot",  a_slot, 4'b0000);
        chk("mrst_xg",    a_xg, 3'd0);
        start_a = 1'b1; step(); start_a = 1'b0;
        step();
        for (int i = 1; i <= 4; i++) pair_a(3'(i), 3'(i), 0);
        chk("rs_k3_fsum", a_f_sum, 5'd10);
        chk("rs_k3_gsum", a_g_sum, 5'd10);
        chk("rs_k3_g2",   a_g2_sum, 8'd30);
        chk("rs_k3_y",    a_y, 1'b0);
        pair_a(3'd5, 3'd5, 0);
        pair_a(3'd6, 3'd6, 0);
        chk("rs_k5_gsum", a_g_sum, 5'd18);
        chk("rs_k5_rd",   a_rd, 1'b1);

        // DUT b: default parameters, all samples at maximum
        start_b = 1'b1; step(); start_b = 1'b0;
        step();
        for (int k = 0; k < 79; k++) begin
            pair_b(3'd7, 3'd7);
            if (k == 14) begin
                chk("b_k14_fsum", b_f_sum, 7'd105);
                chk("b_k14_ov",   b_ov, 1'b0);
            end
            if (k == 15) begin
                chk("b_k15_fsum", b_f_sum, 7'd112);
                chk("b_k15_f2",   b_f2_sum, 10'd784);
                chk("b_k15_gsum", b_g_sum, 7'd112);
                chk("b_k15_g2",   b_g2_sum, 10'd784);
                chk("b_k15_ov",   b_ov, 1'b1);
            end
        end
        chk("b_end_fsum", b_f_sum, 7'd112);
        chk("b_end_f2",   b_f2_sum, 10'd784);
        chk("b_end_gsum", b_g_sum, 7'd112);
        chk("b_end_g2",   b_g2_sum, 10'd784);
        chk("b_end_xg",   b_xg, 7'd78);
        chk("b_end_xf",   b_xf, 4'd14);
        chk("b_end_slot", b_slot, 16'h4000);
        chk("b_end_rd",   b_rd, 1'b1);
        chk("b_end_fd",   b_fd, 1'b0);
        chk("b_end_fwin", b_f_win, 48'hFFFF_FFFF_FFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
